// File: rtl/fetch_unit_if.sv
// RAM read port and decode-side instruction handshake seen by the fetch stage.
// master = fetch unit, slave = the RAM/decode side.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              dmem_req;
    logic [DATA_W-1:0] read_data;
    logic              mem_read;
    logic [ADDR_W-1:0] access_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        input  dmem_req, read_data, instr_ready,
        output mem_read, access_addr, instr_valid, instr_data, instr_pc
    );

    modport slave (
        output dmem_req, read_data, instr_ready,
        input  mem_read, access_addr, instr_valid, instr_data, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single-cycle RAM reads from fetch_pc into a small
// instruction queue, yielding the port to data accesses; supports redirect and halt.
module fetch_unit #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_unit_if.master           bus,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   halt_req,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   halted
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {FETCH, HALTED} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic              head_valid, pop, fetch_en;

    // Redirect outranks everything: it hides the head, blocks pop and fetch.
    always_comb begin
        state_d    = state_q;
        fetch_en   = 1'b0;
        head_valid = (count != '0) && !redirect_valid;
        pop        = head_valid && bus.instr_ready;
        if (redirect_valid) begin
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (halt_req) state_d = HALTED;
            else          fetch_en = !bus.dmem_req && ((count < FULL) || pop);
        end
    end

    // Outputs are forced quiet while reset is held, independent of stored state.
    assign bus.mem_read    = rst_n && fetch_en;
    assign bus.access_addr = fetch_pc;
    assign bus.instr_valid = rst_n && head_valid;
    assign bus.instr_data  = q_data[rd_ptr];
    assign bus.instr_pc    = q_pc[rd_ptr];
    assign queue_count     = rst_n ? count : '0;
    assign halted          = rst_n && (state_q == HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            fetch_pc <= ADDR_W'(RESET_PC);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (fetch_en) begin
                    fetch_pc <= fetch_pc + 1'b1;
                    wr_ptr   <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PTR_W+1)'(fetch_en) - (PTR_W+1)'(pop);
            end
        end
    end

    // Entry storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (rst_n && fetch_en) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_data[wr_ptr] <= bus.read_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a queue-based reference model and a behavioural RAM.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halt_req = 1'b0;
    logic [2:0] queue_count;
    logic       halted;
    logic [7:0] ram [256];

    fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    assign bus.read_data = ram[bus.access_addr];

    fetch_unit #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .queue_count(queue_count), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [7:0] pc; logic [7:0] data; } ent_t;
    ent_t       mq[$];
    logic [7:0] m_pc = 8'h00;
    bit         m_halted = 1'b0;

    function automatic bit m_valid();
        return (mq.size() != 0) && !redirect_valid;
    endfunction

    function automatic bit m_fetch();
        bit pop;
        pop = m_valid() && bus.instr_ready;
        return !m_halted && !bus.dmem_req && !redirect_valid && !halt_req &&
               ((mq.size() < DEPTH) || pop);
    endfunction

    // Advance the model by the cycle whose inputs are currently applied, then clock.
    task automatic tick();
        bit v, f;
        v = m_valid();
        f = m_fetch();
        if (!rst_n) begin
            mq.delete(); m_pc = 8'h00; m_halted = 1'b0;
        end else if (redirect_valid) begin
            mq.delete(); m_pc = redirect_pc; m_halted = 1'b0;
        end else begin
            if (v && bus.instr_ready) void'(mq.pop_front());
            if (f) begin
                mq.push_back({m_pc, ram[m_pc]});
                m_pc = m_pc + 8'd1;
            end
            if (halt_req) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        redirect_valid = 0; redirect_pc = 0; halt_req = 0;
        bus.dmem_req = 0; bus.instr_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.instr_ready = 1; bus.dmem_req = 0; halt_req = 0; redirect_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%0b exp=0", bus.mem_read); end
            checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%0b exp=0", bus.instr_valid); end
            checks++; if (queue_count !== 3'd0) begin failures++; $display("FAIL reset_queue_count got=%0d exp=0", queue_count); end
            checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
            tick();
        end
        checks++; if (bus.access_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%0h exp=00", bus.access_addr); end
        rst_n = 1;
    endtask

    task automatic test_stream();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
        do_reset();
        bus.instr_ready = 1;
        #1;
        checks++; if (bus.mem_read !== 1'b1 || bus.access_addr !== 8'h00) begin failures++; $display("FAIL stream_first_fetch got=%0b/%0h exp=1/00", bus.mem_read, bus.access_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%0b exp=0", bus.instr_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_data !== exp_b[i] || bus.instr_pc !== 8'(i)) begin
                failures++;
                $display("FAIL stream_byte%0d got=%0b/%0h/%0h exp=1/%0h/%0h", i, bus.instr_valid, bus.instr_data, bus.instr_pc, exp_b[i], i);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.instr_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.mem_read !== 1'b1 || bus.access_addr !== 8'(i)) begin failures++; $display("FAIL bp_fetch%0d got=%0b/%0h exp=1/%0h", i, bus.mem_read, bus.access_addr, i); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.mem_read !== 1'b0 || queue_count !== 3'd4 || bus.access_addr !== 8'h04) begin
                failures++; $display("FAIL bp_full got=%0b/%0d/%0h exp=0/4/04", bus.mem_read, queue_count, bus.access_addr);
            end
            tick();
        end
        bus.instr_ready = 1;
        #1;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h11) begin failures++; $display("FAIL bp_pop got=%0b/%0h exp=1/11", bus.instr_valid, bus.instr_data); end
        checks++; if (bus.mem_read !== 1'b1 || bus.access_addr !== 8'h04) begin failures++; $display("FAIL bp_push_on_pop got=%0b/%0h exp=1/04", bus.mem_read, bus.access_addr); end
        tick();
        checks++; if (queue_count !== 3'd4 || bus.instr_pc !== 8'h01) begin failures++; $display("FAIL bp_after got=%0d/%0h exp=4/01", queue_count, bus.instr_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); tick();
        redirect_valid = 1; redirect_pc = 8'h80; bus.instr_ready = 1;
        #1;
        checks++; if (queue_count !== 3'd2) begin failures++; $display("FAIL redir_pre_count got=%0d exp=2", queue_count); end
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_read !== 1'b0) begin failures++; $display("FAIL redir_cycle got=%0b/%0b exp=0/0", bus.instr_valid, bus.mem_read); end
        tick();
        redirect_valid = 0;
        #1;
        checks++; if (queue_count !== 3'd0 || bus.mem_read !== 1'b1 || bus.access_addr !== 8'h80) begin
            failures++; $display("FAIL redir_next got=%0d/%0b/%0h exp=0/1/80", queue_count, bus.mem_read, bus.access_addr);
        end
        tick();
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h80 || bus.instr_data !== ram[8'h80]) begin
            failures++; $display("FAIL redir_head got=%0b/%0h/%0h exp=1/80/%0h", bus.instr_valid, bus.instr_pc, bus.instr_data, ram[8'h80]);
        end
    endtask

    task automatic test_dmem();
        do_reset();
        bus.instr_ready = 1;
        tick(); tick();
        bus.dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.mem_read !== 1'b0 || bus.access_addr !== 8'h02) begin failures++; $display("FAIL dmem_hold%0d got=%0b/%0h exp=0/02", i, bus.mem_read, bus.access_addr); end
            if (i == 0) begin
                checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h01) begin failures++; $display("FAIL dmem_pop got=%0b/%0h exp=1/01", bus.instr_valid, bus.instr_pc); end
            end
            tick();
        end
        bus.dmem_req = 0;
        #1;
        checks++; if (bus.mem_read !== 1'b1 || bus.access_addr !== 8'h02) begin failures++; $display("FAIL dmem_resume got=%0b/%0h exp=1/02", bus.mem_read, bus.access_addr); end
        tick();
        checks++; if (bus.instr_pc !== 8'h02) begin failures++; $display("FAIL dmem_seq got=%0h exp=02", bus.instr_pc); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        do_reset();
        redirect_valid = 1; redirect_pc = 8'hFE; bus.instr_ready = 1;
        tick();
        redirect_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.mem_read !== 1'b1 || bus.access_addr !== exp_a[i]) begin failures++; $display("FAIL wrap_fetch%0d got=%0b/%0h exp=1/%0h", i, bus.mem_read, bus.access_addr, exp_a[i]); end
            if (i > 0) begin
                checks++; if (bus.instr_pc !== exp_a[i-1]) begin failures++; $display("FAIL wrap_pc%0d got=%0h exp=%0h", i, bus.instr_pc, exp_a[i-1]); end
            end
            tick();
        end
    endtask

    task automatic test_halt();
        do_reset();
        tick(); tick(); tick();
        halt_req = 1;
        #1;
        checks++; if (bus.mem_read !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL halt_req_cycle got=%0b/%0b exp=0/0", bus.mem_read, halted); end
        tick();
        halt_req = 0; bus.instr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (halted !== 1'b1 || bus.mem_read !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i)) begin
                failures++; $display("FAIL halt_drain%0d got=%0b/%0b/%0b/%0h exp=1/0/1/%0h", i, halted, bus.mem_read, bus.instr_valid, bus.instr_pc, i);
            end
            tick();
        end
        checks++; if (bus.instr_valid !== 1'b0 || queue_count !== 3'd0 || bus.access_addr !== 8'h03) begin
            failures++; $display("FAIL halt_empty got=%0b/%0d/%0h exp=0/0/03", bus.instr_valid, queue_count, bus.access_addr);
        end
        redirect_valid = 1; redirect_pc = 8'h10;
        tick();
        redirect_valid = 0;
        #1;
        checks++; if (halted !== 1'b0 || bus.mem_read !== 1'b1 || bus.access_addr !== 8'h10) begin
            failures++; $display("FAIL halt_resume got=%0b/%0b/%0h exp=0/1/10", halted, bus.mem_read, bus.access_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst_n           = ($urandom_range(0, 299) != 0);
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.dmem_req    = ($urandom_range(0, 7) == 0);
            halt_req        = ($urandom_range(0, 39) == 0);
            redirect_valid  = ($urandom_range(0, 29) == 0);
            redirect_pc     = 8'($urandom);
            #1;
            checks++; if (bus.mem_read !== (rst_n && m_fetch())) begin failures++; $display("FAIL rand_mem_read c=%0d got=%0b exp=%0b", c, bus.mem_read, rst_n && m_fetch()); end
            checks++; if (bus.access_addr !== m_pc) begin failures++; $display("FAIL rand_addr c=%0d got=%0h exp=%0h", c, bus.access_addr, m_pc); end
            checks++; if (bus.instr_valid !== (rst_n && m_valid())) begin failures++; $display("FAIL rand_valid c=%0d got=%0b exp=%0b", c, bus.instr_valid, rst_n && m_valid()); end
            checks++; if (queue_count !== (rst_n ? 3'(mq.size()) : 3'd0)) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, queue_count, rst_n ? mq.size() : 0); end
            checks++; if (halted !== (rst_n && m_halted)) begin failures++; $display("FAIL rand_halted c=%0d got=%0b exp=%0b", c, halted, rst_n && m_halted); end
            if (rst_n && m_valid()) begin
                checks++; if ({bus.instr_pc, bus.instr_data} !== mq[0]) begin
                    failures++; $display("FAIL rand_head c=%0d got=%0h/%0h exp=%0h/%0h", c, bus.instr_pc, bus.instr_data, mq[0].pc, mq[0].data);
                end
            end
            tick();
        end
        rst_n = 1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 8'($urandom);
        clear_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_dmem();
        test_wrap();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
